// File: rtl/robs_mult_seq.sv
// Sequential multiplier using Robertson's shift-and-add algorithm.
// One iteration per clock: WIDTH iterations per product. A runtime mode bit
// selects two's-complement or unsigned operands. Input side uses start/in_ready;
// output side uses out_valid/out_ready with backpressure.
module robs_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  x;
   logic [WIDTH-1:0]  y;
   logic [CW-1:0]     count;
   logic              mode;

   // One extra accumulator bit keeps the carry (unsigned) or the true sign
   // (signed) so that -2^(W-1) * -2^(W-1) does not overflow.
   logic [WIDTH:0]    ae;
   logic [WIDTH:0]    ye;
   logic [WIDTH:0]    s;

   // Partial-product step: add Y, subtract Y on the final signed step, or pass A.
   always_comb begin
      ae = {mode & a[WIDTH-1], a};
      ye = {mode & y[WIDTH-1], y};
      s  = ae;
      if (x[0]) begin
         if (mode && (count == LAST))
            s = ae - ye;
         else
            s = ae + ye;
      end
   end

   assign product = {a, x};

   // Controller and datapath: state, operand registers and registered handshakes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         a         <= '0;
         x         <= '0;
         y         <= '0;
         count     <= '0;
         mode      <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode     <= signed_mode;
                  a        <= '0;
                  x        <= multiplier;
                  y        <= multiplicand;
                  count    <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               // Shifting S right by one drops the LSB into X; the top bit of S
               // is the sign (signed) or carry (unsigned) shifted into A.
               a     <= s[WIDTH:1];
               x     <= {s[0], x[WIDTH-1:1]};
               count <= count + 1'b1;
               if (count == LAST) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               // Start is not looked at here, so a start coinciding with the
               // hand-off is only accepted on the following cycle.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_robs_mult_seq.sv
// Self-checking bench for robs_mult_seq at WIDTH = 8, 16 and 3.
// Products are checked against plain integer multiplication.
module tb_robs_mult_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        start8, sm8, ir8, busy8, ov8, ordy8;
   logic [7:0]  x8, y8;
   logic [15:0] p8;
   logic        start16, sm16, ir16, busy16, ov16, ordy16;
   logic [15:0] x16, y16;
   logic [31:0] p16;
   logic        start3, sm3, ir3, busy3, ov3, ordy3;
   logic [2:0]  x3, y3;
   logic [5:0]  p3;

   robs_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
      .multiplier(x8), .multiplicand(y8), .in_ready(ir8), .busy(busy8),
      .out_valid(ov8), .out_ready(ordy8), .product(p8));

   robs_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
      .multiplier(x16), .multiplicand(y16), .in_ready(ir16), .busy(busy16),
      .out_valid(ov16), .out_ready(ordy16), .product(p16));

   robs_mult_seq #(.WIDTH(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .signed_mode(sm3),
      .multiplier(x3), .multiplicand(y3), .in_ready(ir3), .busy(busy3),
      .out_valid(ov3), .out_ready(ordy3), .product(p3));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: ordinary integer product of the operands as interpreted by mode.
   function automatic longint unsigned ref_prod(input int w, input bit sm,
                                                input longint unsigned xa, input longint unsigned ya);
      longint unsigned m;
      longint sx, sy;
      m  = (64'd1 << w) - 64'd1;
      sx = longint'(xa & m);
      sy = longint'(ya & m);
      if (sm && sx[w-1]) sx = sx - longint'(64'd1 << w);
      if (sm && sy[w-1]) sy = sy - longint'(64'd1 << w);
      return longint'(sx * sy) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic drive(input int w, input bit st, input bit sm,
                        input longint unsigned xa, input longint unsigned ya, input bit ordy);
      case (w)
         8: begin
            start8 = st; sm8 = sm; x8 = xa[7:0]; y8 = ya[7:0]; ordy8 = ordy;
         end
         16: begin
            start16 = st; sm16 = sm; x16 = xa[15:0]; y16 = ya[15:0]; ordy16 = ordy;
         end
         default: begin
            start3 = st; sm3 = sm; x3 = xa[2:0]; y3 = ya[2:0]; ordy3 = ordy;
         end
      endcase
   endtask

   function automatic bit ov_of(input int w);
      return (w == 8) ? ov8 : (w == 16) ? ov16 : ov3;
   endfunction
   function automatic bit busy_of(input int w);
      return (w == 8) ? busy8 : (w == 16) ? busy16 : busy3;
   endfunction
   function automatic bit ir_of(input int w);
      return (w == 8) ? ir8 : (w == 16) ? ir16 : ir3;
   endfunction
   function automatic longint unsigned prod_of(input int w);
      return (w == 8) ? longint'(p8) : (w == 16) ? longint'(p16) : longint'(p3);
   endfunction

   // One full operation: accept, iterate, optional backpressure hold, optional release.
   task automatic do_op(input int w, input bit sm, input longint unsigned xa, input longint unsigned ya,
                        input int hold, input bit pulse, input bit rel, output longint unsigned prod);
      longint unsigned exp;
      int lat;
      int bcnt;
      exp = ref_prod(w, sm, xa, ya);
      check("idle_before_op", longint'(ir_of(w)), 1);
      drive(w, 1'b1, sm, xa, ya, 1'b0);
      @(posedge clk); #1;
      drive(w, 1'b0, ~sm, $urandom, $urandom, 1'b0);
      lat  = 1;
      bcnt = busy_of(w) ? 1 : 0;
      while (!ov_of(w) && lat < 200) begin
         drive(w, pulse && (lat == 3), ~sm, $urandom, $urandom, 1'b0);
         @(posedge clk); #1;
         lat++;
         if (busy_of(w)) bcnt++;
      end
      drive(w, 1'b0, sm, xa, ya, 1'b0);
      prod = prod_of(w);
      check("latency", longint'(lat), longint'(w + 1));
      check("busy_cycles", longint'(bcnt), longint'(w));
      check("product", prod, exp);
      $display("op w=%0d signed=%0d x=%0h y=%0h product=%0h expected=%0h latency=%0d",
               w, sm, xa & ((64'd1 << w) - 1), ya & ((64'd1 << w) - 1), prod, exp, lat);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", longint'(ov_of(w)), 1);
         check("hold_product", prod_of(w), exp);
      end
      if (rel) begin
         drive(w, 1'b0, sm, xa, ya, 1'b1);
         @(posedge clk); #1;
         drive(w, 1'b0, sm, xa, ya, 1'b0);
         check("back_to_idle", longint'(ir_of(w)), 1);
      end
   endtask

   initial begin
      longint unsigned p;
      int lat;
      reset = 1'b0;
      drive(8, 1'b0, 1'b0, 0, 0, 1'b0);
      drive(16, 1'b0, 1'b0, 0, 0, 1'b0);
      drive(3, 1'b0, 1'b0, 0, 0, 1'b0);
      #12;
      check("rst_in_ready", longint'(ir8), 1);
      check("rst_busy", longint'(busy8), 0);
      check("rst_out_valid", longint'(ov8), 0);
      check("rst_product", longint'(p8), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed WIDTH=8 cases
      do_op(8, 1'b1, 64'hFD, 64'h05, 0, 1'b0, 1'b1, p);
      check("neg3_x_5", p, 64'hFFF1);
      do_op(8, 1'b1, 64'h80, 64'h80, 0, 1'b0, 1'b1, p);
      check("min_x_min", p, 64'h4000);
      do_op(8, 1'b1, 64'h7F, 64'hFF, 0, 1'b0, 1'b1, p);
      check("127_x_neg1", p, 64'hFF81);
      do_op(8, 1'b0, 64'hFF, 64'hFF, 0, 1'b0, 1'b1, p);
      check("u255_x_255", p, 64'hFE01);
      do_op(8, 1'b1, 64'hFF, 64'hFF, 0, 1'b0, 1'b1, p);
      check("s_neg1_x_neg1", p, 64'h0001);
      do_op(8, 1'b0, 64'h00, 64'hA5, 0, 1'b0, 1'b1, p);
      check("zero_operand", p, 64'h0000);

      // Backpressure with start pulse during RUN, then release together with start
      do_op(8, 1'b0, 64'h1D, 64'h2B, 20, 1'b1, 1'b0, p);
      check("bp_product", p, 64'h04DF);
      drive(8, 1'b1, 1'b1, 64'h0A, 64'hF9, 1'b1);
      @(posedge clk); #1;
      check("release_in_ready", longint'(ir8), 1);
      check("release_start_ignored", longint'(busy8), 0);
      drive(8, 1'b1, 1'b1, 64'h0A, 64'hF9, 1'b0);
      @(posedge clk); #1;
      check("late_accept_busy", longint'(busy8), 1);
      drive(8, 1'b0, 1'b0, $urandom, $urandom, 1'b0);
      lat = 1;
      while (!ov8 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("late_latency", longint'(lat), 9);
      check("late_product", longint'(p8), 64'hFFBA);
      $display("op w=8 signed=1 x=0a y=f9 product=%0h expected=ffba latency=%0d", p8, lat);
      drive(8, 1'b0, 1'b0, 0, 0, 1'b1);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 0, 0, 1'b0);

      // Asynchronous reset in the middle of RUN
      drive(8, 1'b1, 1'b1, 64'h55, 64'h33, 1'b0);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b1, 64'h55, 64'h33, 1'b0);
      repeat (4) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("abort_product", longint'(p8), 0);
      check("abort_out_valid", longint'(ov8), 0);
      check("abort_busy", longint'(busy8), 0);
      check("abort_in_ready", longint'(ir8), 1);
      $display("op w=8 aborted by reset");
      #2 reset = 1'b1;
      @(posedge clk); #1;
      do_op(8, 1'b1, 64'h06, 64'h07, 0, 1'b0, 1'b1, p);
      check("after_abort_6x7", p, 64'h002A);

      // Extremes at the other widths
      do_op(16, 1'b1, 64'h8000, 64'h8000, 0, 1'b0, 1'b1, p);
      check("w16_min_x_min", p, 64'h40000000);
      do_op(16, 1'b0, 64'hFFFF, 64'hFFFF, 0, 1'b0, 1'b1, p);
      check("w16_umax_sq", p, 64'hFFFE0001);
      do_op(3, 1'b1, 64'h4, 64'h4, 0, 1'b0, 1'b1, p);
      check("w3_min_x_min", p, 64'h10);
      do_op(3, 1'b0, 64'h7, 64'h7, 0, 1'b0, 1'b1, p);
      check("w3_umax_sq", p, 64'h31);

      // Random operands
      for (int n = 0; n < 500; n++)
         do_op(16, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'b0, 1'b1, p);
      for (int n = 0; n < 500; n++)
         do_op(3, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'b0, 1'b1, p);
      for (int n = 0; n < 100; n++)
         do_op(8, 1'($urandom_range(0, 1)), $urandom, $urandom, 0, 1'b0, 1'b1, p);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
